i2c_target_rx: RTL and testbench

Responder-side I2C engine that pairs with the team's I2C initiator (controller plus `i2c_bit_timer`). It oversamples the bus with the system clock, detects START/STOP, shifts in the address byte and write data bytes, and drives ACK/NACK on SDA. It sits between the open-drain pad cells and a simple byte sink: write transfers only, single 7-bit address.

---
 rtl/i2c_target_rx.sv | 147 ++++++++++++++
 tb/tb_i2c_target_rx.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_rx.sv
// rtl/i2c_target_rx.sv - I2C write-only target: START/STOP detect, byte shift-in, ACK/NACK drive
module i2c_target_rx #(
  parameter logic [6:0] ADDR = 7'h2A
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Scl_i,
  input  logic       Sda_i,
  input  logic       Rx_ready,
  output logic       Sda_oe,
  output logic [7:0] Data_o,
  output logic       Data_valid,
  output logic       Addr_match,
  output logic       Busy
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADDR     = 3'd1,
    S_ADDR_ACK = 3'd2,
    S_DATA     = 3'd3,
    S_DATA_ACK = 3'd4,
    S_IGNORE   = 3'd5
  } state_t;

  state_t     state, state_next;

  logic       scl_s1, scl_s2, scl_h;
  logic       sda_s1, sda_s2, sda_h;
  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] shreg;
  logic [2:0] bit_cnt;
  logic       byte_full;
  logic       capture;
  logic [7:0] rx_byte;

  // Two-stage synchronizers plus one history stage; idle bus reads as high
  always_ff @(posedge Clk) begin
    if (Rst) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_h  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_h  <= 1'b1;
    end else begin
      scl_s1 <= Scl_i;
      scl_s2 <= scl_s1;
      scl_h  <= scl_s2;
      sda_s1 <= Sda_i;
      sda_s2 <= sda_s1;
      sda_h  <= sda_s2;
    end
  end

  // Bus events from synchronized value versus history; START/STOP need SCL high on both samples
  always_comb begin
    scl_rise  = scl_s2 & ~scl_h;
    scl_fall  = ~scl_s2 & scl_h;
    start_det = scl_s2 & scl_h & ~sda_s2 & sda_h;
    stop_det  = scl_s2 & scl_h & sda_s2 & ~sda_h;
    rx_byte   = {shreg[6:0], sda_s2};
  end

  // State register
  always_ff @(posedge Clk) begin
    if (Rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state: STOP beats START beats SCL edges; a byte decision waits for the fall after bit 8
  always_comb begin
    state_next = state;
    if (stop_det) begin
      state_next = S_IDLE;
    end else if (start_det) begin
      state_next = S_ADDR;
    end else begin
      case (state)
        S_IDLE:     state_next = S_IDLE;
        S_ADDR: begin
          if (scl_fall && byte_full) begin
            if (shreg[7:1] == ADDR && !shreg[0]) state_next = S_ADDR_ACK;
            else                                 state_next = S_IGNORE;
          end
        end
        S_ADDR_ACK: if (scl_fall) state_next = S_DATA;
        S_DATA: begin
          if (scl_fall && byte_full) state_next = Rx_ready ? S_DATA_ACK : S_IGNORE;
        end
        S_DATA_ACK: if (scl_fall) state_next = S_DATA;
        S_IGNORE:   state_next = S_IGNORE;
        default:    state_next = S_IDLE;
      endcase
    end
  end

  // Outputs decoded from state: ACK drive lives exactly in the two ACK states
  always_comb begin
    Sda_oe  = (state == S_ADDR_ACK) || (state == S_DATA_ACK);
    capture = scl_rise && !byte_full && !start_det && !stop_det &&
              ((state == S_ADDR) || (state == S_DATA));
  end

  // Shift register, bit counter and sink-facing flags
  always_ff @(posedge Clk) begin
    if (Rst) begin
      shreg      <= 8'h00;
      bit_cnt    <= 3'd0;
      byte_full  <= 1'b0;
      Data_o     <= 8'h00;
      Data_valid <= 1'b0;
      Addr_match <= 1'b0;
      Busy       <= 1'b0;
    end else begin
      Data_valid <= 1'b0;
      if (stop_det) begin
        Busy       <= 1'b0;
        Addr_match <= 1'b0;
        bit_cnt    <= 3'd0;
        byte_full  <= 1'b0;
      end else if (start_det) begin
        Busy       <= 1'b1;
        Addr_match <= 1'b0;
        bit_cnt    <= 3'd0;
        byte_full  <= 1'b0;
      end else begin
        if (capture) begin
          shreg   <= rx_byte;
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            byte_full <= 1'b1;
            if (state == S_DATA) begin
              Data_o     <= rx_byte;
              Data_valid <= 1'b1;
            end
          end
        end
        if (scl_fall && byte_full && ((state == S_ADDR) || (state == S_DATA)))
          byte_full <= 1'b0;
        if (scl_fall && (state == S_ADDR_ACK))
          Addr_match <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_rx.sv
// tb/tb_i2c_target_rx.sv - self-checking bench for i2c_target_rx
module tb_i2c_target_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_tb = 1'b1;
  logic       sda_tb = 1'b1;
  logic       rx_ready = 1'b1;
  logic       sda_oe;
  logic [7:0] data_o;
  logic       data_valid, addr_match, busy;
  logic       sda_line;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] dv_q[$];
  int         oe_rises = 0;
  logic       oe_prev = 1'b0;
  logic       dv_prev = 1'b0;

  assign sda_line = sda_tb & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target_rx #(.ADDR(7'h2A)) dut (
    .Clk       (clk),
    .Rst       (rst),
    .Scl_i     (scl_tb),
    .Sda_i     (sda_line),
    .Rx_ready  (rx_ready),
    .Sda_oe    (sda_oe),
    .Data_o    (data_o),
    .Data_valid(data_valid),
    .Addr_match(addr_match),
    .Busy      (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: collect delivered bytes, count ACK drive windows, check pulse width
  always @(negedge clk) begin
    if (data_valid) begin
      dv_q.push_back(data_o);
      chk("dv_width", {31'b0, dv_prev}, 32'd0);
    end
    if (sda_oe && !oe_prev) oe_rises++;
    oe_prev = sda_oe;
    dv_prev = data_valid;
  end

  task automatic wcyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    if (!scl_tb) begin
      sda_tb = 1'b1; wcyc(3);
      scl_tb = 1'b1; wcyc(6);
    end
    sda_tb = 1'b0; wcyc(6);
    scl_tb = 1'b0; wcyc(3);
  endtask

  task automatic bus_stop(input bit chk_lat);
    sda_tb = 1'b0; wcyc(3);
    scl_tb = 1'b1; wcyc(6);
    sda_tb = 1'b1;
    wcyc(2);
    if (chk_lat) chk("busy_before_stop_lat", {31'b0, busy}, 32'd1);
    wcyc(1);
    if (chk_lat) chk("busy_after_stop_lat", {31'b0, busy}, 32'd0);
    wcyc(3);
  endtask

  task automatic send_bit(input logic b);
    sda_tb = b;    wcyc(4);
    scl_tb = 1'b1; wcyc(6);
    scl_tb = 1'b0; wcyc(3);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_tb = 1'b1; wcyc(4);
    scl_tb = 1'b1; wcyc(3);
    ack = (sda_line == 1'b0);
    wcyc(3);
    scl_tb = 1'b0; wcyc(3);
  endtask

  // Reference: target ACKs its write address, then each byte while the sink is ready;
  // every byte seen while still listening is delivered; after any NACK it goes deaf.
  task automatic model(input logic [7:0] a, input int n, input logic [7:0] d0, d1, d2,
                       input logic [2:0] rdy, output logic aack, output logic [2:0] dack,
                       output int ndv, output logic [7:0] v0, v1, v2, output logic match);
    logic [7:0] d[3];
    logic [7:0] v[3];
    logic live;
    d[0] = d0; d[1] = d1; d[2] = d2;
    v[0] = 8'h00; v[1] = 8'h00; v[2] = 8'h00;
    aack = (a == 8'h54);
    match = aack;
    live = aack;
    dack = 3'b000;
    ndv = 0;
    for (int i = 0; i < n; i++) begin
      if (live) begin
        v[ndv] = d[i];
        ndv++;
        dack[i] = rdy[i];
        live = rdy[i];
      end
    end
    v0 = v[0]; v1 = v[1]; v2 = v[2];
  endtask

  task automatic xfer(input logic [7:0] a, input int n, input logic [7:0] d0, d1, d2,
                      input logic [2:0] rdy, input logic aack_e, input logic [2:0] dack_e,
                      input int ndv_e, input logic [7:0] v0, v1, v2, input logic match_e);
    logic ack;
    logic [7:0] d[3];
    logic [7:0] v[3];
    d[0] = d0; d[1] = d1; d[2] = d2;
    v[0] = v0; v[1] = v1; v[2] = v2;
    dv_q.delete();
    oe_rises = 0;
    bus_start();
    chk("busy_after_start", {31'b0, busy}, 32'd1);
    send_byte(a, ack);
    chk("addr_ack", {31'b0, ack}, {31'b0, aack_e});
    chk("addr_match", {31'b0, addr_match}, {31'b0, match_e});
    for (int i = 0; i < n; i++) begin
      rx_ready = rdy[i];
      send_byte(d[i], ack);
      chk("data_ack", {31'b0, ack}, {31'b0, dack_e[i]});
    end
    bus_stop(1'b1);
    chk("addr_match_after_stop", {31'b0, addr_match}, 32'd0);
    chk("dv_count", dv_q.size(), ndv_e);
    for (int i = 0; i < ndv_e && i < dv_q.size(); i++)
      chk("dv_value", {24'b0, dv_q[i]}, {24'b0, v[i]});
    chk("oe_windows", oe_rises, {31'b0, aack_e} + dack_e[0] + dack_e[1] + dack_e[2]);
    rx_ready = 1'b1;
  endtask

  typedef struct {
    logic [7:0] a;
    int         n;
    logic [7:0] d0, d1, d2;
    logic [2:0] rdy;
    logic       aack;
    logic [2:0] dack;
    int         ndv;
    logic [7:0] v0, v1, v2;
    logic       match;
  } tv_t;

  tv_t tv[5];

  initial begin
    logic ack;
    logic aack_m, match_m;
    logic [2:0] dack_m;
    int ndv_m;
    logic [7:0] a, d0, d1, d2, v0, v1, v2;
    logic [2:0] rdy;
    int n;

    tv[0] = '{8'h54, 1, 8'hA5, 8'h00, 8'h00, 3'b001, 1'b1, 3'b001, 1, 8'hA5, 8'h00, 8'h00, 1'b1};
    tv[1] = '{8'h56, 1, 8'hFF, 8'h00, 8'h00, 3'b001, 1'b0, 3'b000, 0, 8'h00, 8'h00, 8'h00, 1'b0};
    tv[2] = '{8'h55, 0, 8'h00, 8'h00, 8'h00, 3'b000, 1'b0, 3'b000, 0, 8'h00, 8'h00, 8'h00, 1'b0};
    tv[3] = '{8'h54, 2, 8'h3C, 8'h11, 8'h00, 3'b010, 1'b1, 3'b000, 1, 8'h3C, 8'h00, 8'h00, 1'b1};
    tv[4] = '{8'h54, 3, 8'h01, 8'h02, 8'h03, 3'b111, 1'b1, 3'b111, 3, 8'h01, 8'h02, 8'h03, 1'b1};

    // Reset state
    wcyc(3);
    chk("rst_sda_oe", {31'b0, sda_oe}, 32'd0);
    chk("rst_data_o", {24'b0, data_o}, 32'd0);
    chk("rst_data_valid", {31'b0, data_valid}, 32'd0);
    chk("rst_addr_match", {31'b0, addr_match}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    rst = 1'b0;
    wcyc(5);

    // Directed table
    for (int i = 0; i < 5; i++)
      xfer(tv[i].a, tv[i].n, tv[i].d0, tv[i].d1, tv[i].d2, tv[i].rdy, tv[i].aack,
           tv[i].dack, tv[i].ndv, tv[i].v0, tv[i].v1, tv[i].v2, tv[i].match);
    chk("data_o_hold", {24'b0, data_o}, 32'h03);

    // Repeated START after a partial byte discards it
    dv_q.delete();
    bus_start();
    send_byte(8'h54, ack);
    chk("rs_first_ack", {31'b0, ack}, 32'd1);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    bus_start();
    chk("rs_addr_match_clear", {31'b0, addr_match}, 32'd0);
    chk("rs_busy", {31'b0, busy}, 32'd1);
    send_byte(8'h54, ack);
    chk("rs_second_ack", {31'b0, ack}, 32'd1);
    send_byte(8'h0F, ack);
    chk("rs_data_ack", {31'b0, ack}, 32'd1);
    bus_stop(1'b1);
    chk("rs_dv_count", dv_q.size(), 32'd1);
    chk("rs_data_o", {24'b0, data_o}, 32'h0F);

    // Reset in the middle of the address ACK
    bus_start();
    for (int i = 7; i >= 0; i--) send_bit(a_bit(8'h54, i));
    sda_tb = 1'b1;
    wcyc(2);
    chk("mid_ack_oe", {31'b0, sda_oe}, 32'd1);
    rst = 1'b1;
    wcyc(1);
    chk("rst_ack_oe", {31'b0, sda_oe}, 32'd0);
    chk("rst_ack_busy", {31'b0, busy}, 32'd0);
    chk("rst_ack_match", {31'b0, addr_match}, 32'd0);
    chk("rst_ack_data", {24'b0, data_o}, 32'd0);
    rst = 1'b0;
    wcyc(3);
    bus_stop(1'b0);
    xfer(8'h54, 1, 8'h81, 8'h00, 8'h00, 3'b001, 1'b1, 3'b001, 1, 8'h81, 8'h00, 8'h00, 1'b1);

    // Randomized transfers against the reference model
    for (int t = 0; t < 30; t++) begin
      case ($urandom_range(0, 4))
        0, 1:    a = 8'h54;
        2:       a = 8'h55;
        3:       a = 8'h56;
        default: a = 8'($urandom_range(0, 255));
      endcase
      n   = $urandom_range(0, 3);
      d0  = 8'($urandom_range(0, 255));
      d1  = 8'($urandom_range(0, 255));
      d2  = 8'($urandom_range(0, 255));
      rdy = 3'($urandom_range(0, 7));
      model(a, n, d0, d1, d2, rdy, aack_m, dack_m, ndv_m, v0, v1, v2, match_m);
      xfer(a, n, d0, d1, d2, rdy, aack_m, dack_m, ndv_m, v0, v1, v2, match_m);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  function automatic logic a_bit(input logic [7:0] b, input int i);
    return b[i];
  endfunction

endmodule
